// File: rtl/key_dir_filter.sv
// key_dir_filter: frame-rate W/A/S/D keycode front end for the ball stage.
// It picks one direction key from the two HID slots and debounces it over
// DEBOUNCE_FRAMES frames. It also emits a one-frame press pulse and a
// wrapping count of accepted presses.
module key_dir_filter #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode_in,
  output logic [15:0] keycode,
  output logic        new_press,
  output logic [7:0]  key_count
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] D_MAX = CW'(DEBOUNCE_FRAMES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  logic [7:0]    pend, accepted, cand, acc_nxt;
  logic [CW-1:0] cnt, n;
  logic [1:0]    state, state_nxt;
  logic          accept;

  wire [7:0] slot0 = keycode_in[7:0];
  wire [7:0] slot1 = keycode_in[15:8];

  function automatic logic is_dir(input logic [7:0] k);
    return (k == 8'h1A) || (k == 8'h04) || (k == 8'h16) || (k == 8'h07);
  endfunction

  // Candidate selection: a new key in slot1 overrides the key already held.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand = 8'h00;
    if (is_dir(slot1) && (slot1 != accepted)) cand = slot1;
    else if (is_dir(slot0))                   cand = slot0;
    else if (is_dir(slot1))                   cand = slot1;
  end

  // Debounce count, acceptance decision and next state for this edge.
  always_comb begin
    n = CW'(1);
    if (cand == pend) begin
      // A steady held key, or a full count, stays saturated and never wraps.
      if ((state == S_HELD) || (cnt >= D_MAX)) n = D_MAX;
      else                                     n = cnt + 1'b1;
    end
    accept  = (n >= D_MAX) && (cand != accepted);
    acc_nxt = accept ? cand : accepted;
    if ((acc_nxt != 8'h00) && (cand == acc_nxt))      state_nxt = S_HELD;
    else if ((acc_nxt == 8'h00) && (cand == 8'h00))   state_nxt = S_IDLE;
    else                                              state_nxt = S_PENDING;
  end

  // Frame registers. Reset also clears any candidate that is partly debounced.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pend      <= 8'h00;
      cnt       <= '0;
      accepted  <= 8'h00;
      state     <= S_IDLE;
      new_press <= 1'b0;
      key_count <= 8'h00;
    end else begin
      pend      <= cand;
      cnt       <= n;
      accepted  <= acc_nxt;
      state     <= state_nxt;
      new_press <= accept && (cand != 8'h00);
      if (accept && (cand != 8'h00)) key_count <= key_count + 8'd1;
    end
  end

  assign keycode = {8'h00, accepted};

endmodule

// File: tb/tb_key_dir_filter.sv
// Directed testbench for key_dir_filter with the default DEBOUNCE_FRAMES of 2.
module tb_key_dir_filter;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode_in;
  logic [15:0] keycode;
  logic        new_press;
  logic [7:0]  key_count;

  int n_cmp = 0;
  int n_bad = 0;

  key_dir_filter #(.DEBOUNCE_FRAMES(2)) u_dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode_in(keycode_in),
    .keycode   (keycode),
    .new_press (new_press),
    .key_count (key_count)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one frame, then sample shortly after the edge.
  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] kc, input logic np,
                            input logic [7:0] cntv);
    check({tag, ".keycode"}, keycode, kc);
    check({tag, ".new_press"}, {15'd0, new_press}, {15'd0, np});
    check({tag, ".key_count"}, {8'd0, key_count}, {8'd0, cntv});
  endtask

  initial begin
    // Reset is held while a key is already down.
    keycode_in = 16'h001A;
    Reset = 1'b1;
    #2;
    expect_out("reset_now", 16'h0000, 1'b0, 8'd0);
    step(3);
    expect_out("reset_held", 16'h0000, 1'b0, 8'd0);
    Reset = 1'b0;

    // Basic press: the key is accepted at the second edge with a one-frame pulse.
    step(1); expect_out("press_e1", 16'h0000, 1'b0, 8'd0);
    step(1); expect_out("press_e2", 16'h001A, 1'b1, 8'd1);
    step(1); expect_out("press_e3", 16'h001A, 1'b0, 8'd1);
    step(1); expect_out("press_e4", 16'h001A, 1'b0, 8'd1);

    // Release is debounced the same way, and it gives no pulse.
    keycode_in = 16'h0000;
    step(1); expect_out("rel_e1", 16'h001A, 1'b0, 8'd1);
    step(1); expect_out("rel_e2", 16'h0000, 1'b0, 8'd1);

    // A one-frame glitch is rejected.
    keycode_in = 16'h0004;
    step(1); expect_out("glitch_e1", 16'h0000, 1'b0, 8'd1);
    keycode_in = 16'h0000;
    step(1); expect_out("glitch_e2", 16'h0000, 1'b0, 8'd1);
    step(1); expect_out("glitch_e3", 16'h0000, 1'b0, 8'd1);

    // A new key in slot1 overrides the held W.
    keycode_in = 16'h001A;
    step(2); expect_out("ovr_hold", 16'h001A, 1'b1, 8'd2);
    keycode_in = 16'h071A;
    step(1); expect_out("ovr_e1", 16'h001A, 1'b0, 8'd2);
    step(1); expect_out("ovr_e2", 16'h0007, 1'b1, 8'd3);
    keycode_in = 16'h0700;
    step(1); expect_out("ovr_s0rel1", 16'h0007, 1'b0, 8'd3);
    step(2); expect_out("ovr_s0rel3", 16'h0007, 1'b0, 8'd3);

    // A non-direction key acts as a release. It is ignored when paired with S.
    keycode_in = 16'h0016;
    step(1); expect_out("s_e1", 16'h0007, 1'b0, 8'd3);
    step(1); expect_out("s_e2", 16'h0016, 1'b1, 8'd4);
    keycode_in = 16'h0029;
    step(1); expect_out("esc_e1", 16'h0016, 1'b0, 8'd4);
    step(1); expect_out("esc_e2", 16'h0000, 1'b0, 8'd4);
    keycode_in = 16'h2916;
    step(1); expect_out("mix_e1", 16'h0000, 1'b0, 8'd4);
    step(1); expect_out("mix_e2", 16'h0016, 1'b1, 8'd5);

    // Wrap the counter: reset, then run 256 press/release cycles of A.
    Reset = 1'b1;
    #2;
    expect_out("wrap_rst", 16'h0000, 1'b0, 8'd0);
    keycode_in = 16'h0000;
    Reset = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      keycode_in = 16'h0004;
      step(2);
      if (c == 255) expect_out("wrap_255", 16'h0004, 1'b1, 8'd255);
      keycode_in = 16'h0000;
      step(2);
    end
    expect_out("wrap_0", 16'h0000, 1'b0, 8'd0);

    // Reset while a candidate is only partly debounced.
    keycode_in = 16'h0007;
    step(1);
    Reset = 1'b1;
    #1;
    expect_out("midrst_now", 16'h0000, 1'b0, 8'd0);
    step(1);
    keycode_in = 16'h0000;
    Reset = 1'b0;
    step(1); expect_out("midrst_e1", 16'h0000, 1'b0, 8'd0);
    // A single D frame after reset must not complete the cleared candidate.
    keycode_in = 16'h0007;
    step(1); expect_out("midrst_d1", 16'h0000, 1'b0, 8'd0);
    step(1); expect_out("midrst_d2", 16'h0007, 1'b1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
